// File: rtl/video_pattern_pkg.sv
// video_pattern_pkg: shared constants and types for video_pattern_source.
// Optional feature macro: VIDEO_PATTERN_SOURCE_CTRL_PKT_EN (adds control packet states).
package video_pattern_pkg;

  // Control slave register map
  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_SIZE    = 2'd1;
  localparam logic [1:0] ADDR_PATTERN = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // Avalon-ST video packet type nibbles
  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL  = 4'hF;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_GRADIENT = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_RSVD     = 2'd3
  } pattern_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
`ifdef VIDEO_PATTERN_SOURCE_CTRL_PKT_EN
    ST_CTRL_HDR  = 3'd1,
    ST_CTRL_BODY = 3'd2,
`endif
    ST_DATA_HDR  = 3'd3,
    ST_PIXELS    = 3'd4
  } state_e;

  // Payload of control packet beat 1..3: three nibbles per beat in the
  // low nibble of each colour symbol, first nibble in the B symbol.
  function automatic logic [23:0] ctrl_beat(input logic [1:0] beat,
                                            input logic [15:0] w,
                                            input logic [15:0] h);
    logic [23:0] d;
    case (beat)
      2'd1:    d = {4'h0, w[7:4],  4'h0, w[11:8],  4'h0, w[15:12]};
      2'd2:    d = {4'h0, h[11:8], 4'h0, h[15:12], 4'h0, w[3:0]};
      2'd3:    d = {4'h0, 4'h3,    4'h0, h[3:0],   4'h0, h[7:4]};
      default: d = {20'h0, PKT_CTRL};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/video_pattern_source_pixel_gen.sv
// vps_pixel_gen: combinational pixel colour for coordinate (x, y).
// Only the low byte of each coordinate matters to any pattern.
module vps_pixel_gen
  import video_pattern_pkg::*;
(
  input  logic [7:0]  x_i,
  input  logic [7:0]  y_i,
  input  logic [1:0]  mode_i,
  input  logic [23:0] color_i,
  output logic [23:0] rgb_o
);

  // Pattern mux; the reserved mode falls back to solid colour
  always_comb begin
    rgb_o = color_i;
    case (pattern_mode_e'(mode_i))
      MODE_GRADIENT: rgb_o = {x_i, y_i, x_i ^ y_i};
      MODE_CHECKER:  rgb_o = (x_i[3] ^ y_i[3]) ? ~color_i : color_i;
      default:       rgb_o = color_i;
    endcase
  end

endmodule

// File: rtl/video_pattern_source.sv
// video_pattern_source: Avalon-ST synthetic RGB frame generator with an
// Avalon-MM control slave. Define VIDEO_PATTERN_SOURCE_CTRL_PKT_EN to
// precede every frame with a 4-beat Avalon-ST video control packet.
module video_pattern_source
  import video_pattern_pkg::*;
#(
  parameter int          DEFAULT_WIDTH  = 640,
  parameter int          DEFAULT_HEIGHT = 480,
  parameter logic [23:0] DEFAULT_COLOR  = 24'hFF0000
)(
  input  logic        sys_clk_clk,
  input  logic        sys_reset_reset,
  input  logic [1:0]  pattern_control_slave_address,
  input  logic        pattern_control_slave_write_n,
  input  logic [31:0] pattern_control_slave_writedata,
  input  logic        pattern_control_slave_chipselect,
  output logic [31:0] pattern_control_slave_readdata,
  input  logic        video_stream_source_ready,
  output logic [23:0] video_stream_source_data,
  output logic        video_stream_source_startofpacket,
  output logic        video_stream_source_endofpacket,
  output logic        video_stream_source_valid
);

  logic clk, rst;
  assign clk = sys_clk_clk;
  assign rst = sys_reset_reset;

  // Software-visible registers
  logic        ctrl_en_q, ctrl_single_q;
  logic [15:0] size_w_q, size_h_q;
  logic [1:0]  pat_mode_q;
  logic [23:0] pat_color_q;
  logic [15:0] frame_cnt_q;
  logic [31:0] readdata_q;

  // Frame configuration frozen at frame start
  logic [15:0] fw_q, fh_q;
  logic [1:0]  fmode_q;
  logic [23:0] fcolor_q;

  // FSM, raster position of the presented pixel, registered stream beat
  state_e      state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [23:0] data_q, data_d;
`ifdef VIDEO_PATTERN_SOURCE_CTRL_PKT_EN
  logic [1:0]  beat_q, beat_d;
`endif

  logic        cfg_load, frame_done, start_frame;
  logic        reg_wr, ctrl_wr, xfer, eff_en, eff_single;
  logic [15:0] px_x, px_y;
  logic        px_last;
  logic [23:0] px_rgb;

  assign reg_wr  = pattern_control_slave_chipselect & ~pattern_control_slave_write_n;
  assign ctrl_wr = reg_wr && (pattern_control_slave_address == ADDR_CONTROL);
  assign xfer    = valid_q && video_stream_source_ready;

  // A CONTROL write coinciding with eop acceptance decides continue/stop
  assign eff_en     = ctrl_wr ? pattern_control_slave_writedata[0] : ctrl_en_q;
  assign eff_single = ctrl_wr ? pattern_control_slave_writedata[1] : ctrl_single_q;

  // Coordinate of the pixel after the one presented (origin before the first)
  always_comb begin
    px_x = 16'd0;
    px_y = 16'd0;
    if (state_q == ST_PIXELS) begin
      if (x_q == fw_q - 16'd1) begin
        px_x = 16'd0;
        px_y = y_q + 16'd1;
      end else begin
        px_x = x_q + 16'd1;
        px_y = y_q;
      end
    end
  end

  assign px_last = (px_x == fw_q - 16'd1) && (px_y == fh_q - 16'd1);

  vps_pixel_gen u_pixel_gen (
    .x_i     (px_x[7:0]),
    .y_i     (px_y[7:0]),
    .mode_i  (fmode_q),
    .color_i (fcolor_q),
    .rgb_o   (px_rgb)
  );

  // Register file writes, including SINGLE-mode self-clear of ENABLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en_q     <= 1'b0;
      ctrl_single_q <= 1'b0;
      size_w_q      <= 16'(DEFAULT_WIDTH);
      size_h_q      <= 16'(DEFAULT_HEIGHT);
      pat_mode_q    <= 2'd0;
      pat_color_q   <= DEFAULT_COLOR;
      frame_cnt_q   <= 16'd0;
    end else begin
      if (reg_wr) begin
        case (pattern_control_slave_address)
          ADDR_CONTROL: begin
            ctrl_en_q     <= pattern_control_slave_writedata[0];
            ctrl_single_q <= pattern_control_slave_writedata[1];
          end
          ADDR_SIZE: begin
            size_w_q <= (pattern_control_slave_writedata[15:0] == 16'd0) ?
                        16'd1 : pattern_control_slave_writedata[15:0];
            size_h_q <= (pattern_control_slave_writedata[31:16] == 16'd0) ?
                        16'd1 : pattern_control_slave_writedata[31:16];
          end
          ADDR_PATTERN: begin
            pat_mode_q  <= pattern_control_slave_writedata[1:0];
            pat_color_q <= pattern_control_slave_writedata[31:8];
          end
          default: ;
        endcase
      end
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        if (eff_single) ctrl_en_q <= 1'b0;
      end
    end
  end

  // Registered read port, address sampled every clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata_q <= 32'd0;
    end else begin
      case (pattern_control_slave_address)
        ADDR_CONTROL: readdata_q <= {30'd0, ctrl_single_q, ctrl_en_q};
        ADDR_SIZE:    readdata_q <= {size_h_q, size_w_q};
        ADDR_PATTERN: readdata_q <= {pat_color_q, 6'd0, pat_mode_q};
        default:      readdata_q <= {frame_cnt_q, 15'd0, state_q != ST_IDLE};
      endcase
    end
  end

  // Next-beat generation: FSM state names the beat currently presented
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    valid_d     = valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    data_d      = data_q;
    cfg_load    = 1'b0;
    frame_done  = 1'b0;
    start_frame = 1'b0;
`ifdef VIDEO_PATTERN_SOURCE_CTRL_PKT_EN
    beat_d      = beat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_q) start_frame = 1'b1;
      end
`ifdef VIDEO_PATTERN_SOURCE_CTRL_PKT_EN
      ST_CTRL_HDR: begin
        if (xfer) begin
          state_d = ST_CTRL_BODY;
          beat_d  = 2'd1;
          sop_d   = 1'b0;
          eop_d   = 1'b0;
          data_d  = ctrl_beat(2'd1, fw_q, fh_q);
        end
      end
      ST_CTRL_BODY: begin
        if (xfer) begin
          if (beat_q == 2'd3) begin
            state_d = ST_DATA_HDR;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
            data_d  = {20'd0, PKT_VIDEO};
          end else begin
            beat_d  = beat_q + 2'd1;
            eop_d   = (beat_q == 2'd2);
            data_d  = ctrl_beat(beat_q + 2'd1, fw_q, fh_q);
          end
        end
      end
`endif
      ST_DATA_HDR: begin
        if (xfer) begin
          state_d = ST_PIXELS;
          x_d     = 16'd0;
          y_d     = 16'd0;
          sop_d   = 1'b0;
          eop_d   = px_last;
          data_d  = px_rgb;
        end
      end
      ST_PIXELS: begin
        if (xfer) begin
          if (eop_q) begin
            frame_done = 1'b1;
            if (eff_en && !eff_single) begin
              start_frame = 1'b1;
            end else begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
              data_d  = 24'd0;
            end
          end else begin
            x_d    = px_x;
            y_d    = px_y;
            sop_d  = 1'b0;
            eop_d  = px_last;
            data_d = px_rgb;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        data_d  = 24'd0;
      end
    endcase
    if (start_frame) begin
      cfg_load = 1'b1;
      valid_d  = 1'b1;
      sop_d    = 1'b1;
      eop_d    = 1'b0;
`ifdef VIDEO_PATTERN_SOURCE_CTRL_PKT_EN
      state_d  = ST_CTRL_HDR;
      beat_d   = 2'd0;
      data_d   = {20'd0, PKT_CTRL};
`else
      state_d  = ST_DATA_HDR;
      data_d   = {20'd0, PKT_VIDEO};
`endif
    end
  end

  // FSM and stream output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= 24'd0;
`ifdef VIDEO_PATTERN_SOURCE_CTRL_PKT_EN
      beat_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      data_q  <= data_d;
`ifdef VIDEO_PATTERN_SOURCE_CTRL_PKT_EN
      beat_q  <= beat_d;
`endif
    end
  end

  // Raster counters; only meaningful once DATA_HDR has cleared them
  always_ff @(posedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
  end

  // Frame configuration snapshot taken as each frame's first header issues
  always_ff @(posedge clk) begin
    if (cfg_load) begin
      fw_q     <= size_w_q;
      fh_q     <= size_h_q;
      fmode_q  <= pat_mode_q;
      fcolor_q <= pat_color_q;
    end
  end

  assign pattern_control_slave_readdata    = readdata_q;
  assign video_stream_source_data          = data_q;
  assign video_stream_source_startofpacket = sop_q;
  assign video_stream_source_endofpacket   = eop_q;
  assign video_stream_source_valid         = valid_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// Scoreboard bench for video_pattern_source: a reference model pushes
// expected beats; a monitor pops and compares on every accepted beat.
module tb_video_pattern_source;

`ifdef VIDEO_PATTERN_SOURCE_CTRL_PKT_EN
  localparam int HDR_BEATS = 5;
`else
  localparam int HDR_BEATS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        wn;
  logic [31:0] wdata;
  logic        cs;
  logic [31:0] readdata;
  logic        ready;
  logic [23:0] data;
  logic        sop, eop, valid;

  video_pattern_source dut (
    .sys_clk_clk                       (clk),
    .sys_reset_reset                   (rst),
    .pattern_control_slave_address     (addr),
    .pattern_control_slave_write_n     (wn),
    .pattern_control_slave_writedata   (wdata),
    .pattern_control_slave_chipselect  (cs),
    .pattern_control_slave_readdata    (readdata),
    .video_stream_source_ready         (ready),
    .video_stream_source_data          (data),
    .video_stream_source_startofpacket (sop),
    .video_stream_source_endofpacket   (eop),
    .video_stream_source_valid         (valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [25:0] exp_q[$];
  int          xfer_cyc[$];
  int          checks = 0, errors = 0;
  int          xfer_cnt = 0, eop_cnt = 0, fc_model = 0, last_wr_cyc = 0;
  bit          rand_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [23:0] model_pix(input int x, input int y, input int mode,
                                            input logic [23:0] c);
    logic [23:0] p;
    if (mode == 1)
      p = {8'(x % 256), 8'(y % 256), 8'((x % 256) ^ (y % 256))};
    else if (mode == 2)
      p = ((((x / 8) + (y / 8)) % 2) == 0) ? c : ~c;
    else
      p = c;
    return p;
  endfunction

  task automatic push_frame(input int w, input int h, input int mode, input logic [23:0] c);
`ifdef VIDEO_PATTERN_SOURCE_CTRL_PKT_EN
    int nib[9];
    int d;
    nib = '{(w >> 12) & 15, (w >> 8) & 15, (w >> 4) & 15, w & 15,
            (h >> 12) & 15, (h >> 8) & 15, (h >> 4) & 15, h & 15, 3};
    exp_q.push_back({1'b1, 1'b0, 24'h00000F});
    for (int b = 1; b <= 3; b++) begin
      d = nib[3*(b-1)] | (nib[3*(b-1)+1] << 8) | (nib[3*(b-1)+2] << 16);
      exp_q.push_back({1'b0, (b == 3), 24'(d)});
    end
`endif
    exp_q.push_back({1'b1, 1'b0, 24'h000000});
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        exp_q.push_back({1'b0, (x == w-1) && (y == h-1), model_pix(x, y, mode, c)});
    fc_model++;
  endtask

  // ---------------- back-pressure driver ----------------
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  bit          stall_pend = 0;
  logic [25:0] stall_beat;
  logic [25:0] e;
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 0;
    end else begin
      if (stall_pend)
        chk("stall_hold", {5'd0, valid, sop, eop, data}, {5'd0, 1'b1, stall_beat});
      stall_pend = valid && !ready;
      stall_beat = {sop, eop, data};
      if (valid && ready) begin
        xfer_cnt++;
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected actual=%h expected=none", {sop, eop, data});
        end else begin
          e = exp_q.pop_front();
          chk("beat", {6'd0, sop, eop, data}, {6'd0, e});
        end
        if (eop) eop_cnt++;
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cs = 1'b1; wn = 1'b0; addr = a; wdata = d;
    @(posedge clk); #1;
    cs = 1'b0; wn = 1'b1;
    last_wr_cyc = cyc;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    addr = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_xfer(input string name, input int target, input int limit);
    int n = 0;
    while (xfer_cnt < target && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, (xfer_cnt >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] r;
  logic [23:0] col;
  int base, e0, en_cyc, x0, w, h, mode, n;

  initial begin
    rst = 1'b1; cs = 1'b0; wn = 1'b1; addr = 2'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_sop_eop", {sop, eop}, 0);
    chk("rst_data", data, 0);
    chk("rst_readdata", readdata, 0);
    rst = 1'b0;
    rd(2'd0, r); chk("rst_control", r, 32'h0);
    rd(2'd1, r); chk("rst_size", r, {16'd480, 16'd640});
    rd(2'd2, r); chk("rst_pattern", r, {24'hFF0000, 8'h00});
    rd(2'd3, r); chk("rst_status", r, 32'h0);

    // Solid 4x2, continuous: latency and back-to-back frames
    wr(2'd1, {16'd2, 16'd4});
    wr(2'd2, {24'h00FF00, 8'h00});
    base = xfer_cyc.size();
    push_frame(4, 2, 0, 24'h00FF00);
    push_frame(4, 2, 0, 24'h00FF00);
    e0 = eop_cnt;
    wr(2'd0, 32'd1);
    en_cyc = last_wr_cyc;
    n = 0;
    while (eop_cnt == e0 && n < 200) begin @(posedge clk); #1; n++; end
    wr(2'd0, 32'd0);
    drain("solid_drain", 200);
    if (xfer_cyc.size() >= base + 2*(HDR_BEATS+8)) begin
      chk("first_hdr_latency", xfer_cyc[base], en_cyc + 1);
      chk("b2b_span", xfer_cyc[base + 2*(HDR_BEATS+8) - 1] - xfer_cyc[base],
          2*(HDR_BEATS+8) - 1);
    end else begin
      chk("solid_beat_count", xfer_cyc.size() - base, 2*(HDR_BEATS+8));
    end

    // Gradient 4x2, SINGLE
    wr(2'd2, {24'h123456, 8'h01});
    push_frame(4, 2, 1, 24'h123456);
    wr(2'd0, 32'd3);
    drain("grad_drain", 200);
    rd(2'd0, r); chk("single_ctrl", r, 32'h2);
    rd(2'd3, r); chk("single_status", r, {16'(fc_model), 16'h0});

    // Checker 16x16 with random back-pressure; SIZE write mid-frame
    rand_ready = 1;
    col = 24'($urandom);
    wr(2'd1, {16'd16, 16'd16});
    wr(2'd2, {col, 8'h02});
    x0 = xfer_cnt;
    push_frame(16, 16, 2, col);
    wr(2'd0, 32'd3);
    wr(2'd1, {16'd3, 16'd5});
    drain("checker_drain", 4000);
    chk("checker_beats", xfer_cnt - x0, HDR_BEATS + 256);
    push_frame(5, 3, 2, col);
    wr(2'd0, 32'd3);
    drain("resize_drain", 1000);
    rand_ready = 0;

    // Clear ENABLE mid-frame
    col = 24'($urandom);
    wr(2'd1, {16'd2, 16'd4});
    wr(2'd2, {col, 8'h03});
    push_frame(4, 2, 3, col);
    x0 = xfer_cnt;
    wr(2'd0, 32'd1);
    wait_xfer("midclear_wait", x0 + HDR_BEATS + 3, 100);
    wr(2'd0, 32'd0);
    drain("midclear_drain", 200);
    rd(2'd3, r); chk("midclear_status", r, {16'(fc_model), 16'h0});

    // SIZE=0 stored as 1x1
    rand_ready = 1;
    wr(2'd1, 32'd0);
    rd(2'd1, r); chk("size_zero", r, 32'h0001_0001);
    mode = $urandom_range(0, 3);
    col = 24'($urandom);
    wr(2'd2, {col, 6'd0, 2'(mode)});
    push_frame(1, 1, mode, col);
    wr(2'd0, 32'd3);
    drain("one_pixel_drain", 200);

    // Random small frames
    for (int i = 0; i < 4; i++) begin
      w = $urandom_range(1, 9);
      h = $urandom_range(1, 4);
      mode = $urandom_range(0, 3);
      col = 24'($urandom);
      wr(2'd1, {16'(h), 16'(w)});
      wr(2'd2, {col, 6'd0, 2'(mode)});
      rd(2'd2, r); chk("rand_pattern_rb", r, {col, 6'd0, 2'(mode)});
      push_frame(w, h, mode, col);
      wr(2'd0, 32'd3);
      drain("rand_drain", 500);
    end
    rd(2'd3, r); chk("final_status", r, {16'(fc_model), 16'h0});
    rand_ready = 0;

    // Asynchronous reset in the middle of a frame
    wr(2'd1, {16'd8, 16'd8});
    push_frame(8, 8, 0, col);
    x0 = xfer_cnt;
    wr(2'd0, 32'd1);
    wait_xfer("reset_wait", x0 + HDR_BEATS + 4, 100);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {valid, sop, eop}, 0);
    chk("async_rst_data", data, 0);
    chk("async_rst_readdata", readdata, 0);
    exp_q.delete();
    fc_model = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("post_rst_idle", valid, 0);
    rd(2'd0, r); chk("post_rst_control", r, 32'h0);
    rd(2'd1, r); chk("post_rst_size", r, {16'd480, 16'd640});
    rd(2'd3, r); chk("post_rst_status", r, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
